// File: rtl/ultrasonic_range_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ultrasonic_range_ctrl
// Description : HC-SR04-style ranging sequencer. Issues the trigger pulse,
//               waits for echo rise, times the echo width in microseconds,
//               converts it to centimetres and holds off before re-arming.
//               A single prescaler/microsecond counter is shared by every
//               state and restarts on each state entry.
// Revision    : 1.0 - initial release
// ============================================================================
module ultrasonic_range_ctrl #(
    parameter int CLKSPDMHZ  = 100,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 38000,
    parameter int HOLDOFF_US = 60000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        cont,
    input  logic        echo,
    output logic        trig,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] echo_us,
    output logic [9:0]  dist_cm
);

    // Prescaler width; a 1 MHz clock still gets a one-bit counter.
    localparam int c_PW = (CLKSPDMHZ > 1) ? $clog2(CLKSPDMHZ) : 1;

    localparam logic [c_PW-1:0] c_PRE_LAST     = c_PW'(CLKSPDMHZ - 1);
    localparam logic [15:0]     c_TRIG_LAST    = 16'(TRIG_US - 1);
    localparam logic [15:0]     c_TIMEOUT_LAST = 16'(TIMEOUT_US - 1);
    localparam logic [15:0]     c_HOLDOFF_LAST = 16'(HOLDOFF_US - 1);

    // 1130 / 65536 approximates 1/58 (microseconds of round trip per cm).
    localparam logic [31:0]     c_CM_MULT      = 32'd1130;

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_TRIG      = 3'd1;
    localparam logic [2:0] c_WAIT_RISE = 3'd2;
    localparam logic [2:0] c_MEASURE   = 3'd3;
    localparam logic [2:0] c_HOLDOFF   = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;

    logic            r_echo_s1;
    logic            r_echo_s2;
    logic            r_echo_prev;
    logic            w_rise;
    logic            w_fall;

    logic [c_PW-1:0] r_pre;
    logic [15:0]     r_us;
    logic            w_tick;
    logic            w_trig_end;
    logic            w_wait_end;
    logic            w_hold_end;

    logic            w_busy;
    logic            w_pub_meas;
    logic            w_pub_to;

    logic [31:0]     w_prod;
    logic [9:0]      w_dist;

    logic            r_trig;
    logic            r_done;
    logic            r_timeout;
    logic [15:0]     r_echo_us;
    logic [9:0]      r_dist_cm;

    // Two-flop synchronizer for the asynchronous echo pin plus one history flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_echo_s1   <= 1'b0;
            r_echo_s2   <= 1'b0;
            r_echo_prev <= 1'b0;
        end else begin
            r_echo_s1   <= echo;
            r_echo_s2   <= r_echo_s1;
            r_echo_prev <= r_echo_s2;
        end
    end

    // A stale high echo shows no rise until it has been seen low first.
    assign w_rise = r_echo_s2 & ~r_echo_prev;
    assign w_fall = ~r_echo_s2 & r_echo_prev;

    assign w_tick     = (r_pre == c_PRE_LAST);
    assign w_trig_end = w_tick && (r_us == c_TRIG_LAST);
    assign w_wait_end = w_tick && (r_us == c_TIMEOUT_LAST);
    assign w_hold_end = w_tick && (r_us == c_HOLDOFF_LAST);

    // Shared microsecond timebase, restarted whenever the state changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre <= '0;
            r_us  <= '0;
        end else if (w_state_nxt != r_state) begin
            r_pre <= '0;
            r_us  <= '0;
        end else begin
            r_pre <= w_tick ? '0 : (r_pre + c_PW'(1));
            if (w_tick) begin
                r_us <= r_us + 16'd1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an echo edge wins over a timeout landing on the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (start || cont) begin
                    w_state_nxt = c_TRIG;
                end
            end
            c_TRIG: begin
                if (w_trig_end) begin
                    w_state_nxt = c_WAIT_RISE;
                end
            end
            c_WAIT_RISE: begin
                if (w_rise) begin
                    w_state_nxt = c_MEASURE;
                end else if (w_wait_end) begin
                    w_state_nxt = c_HOLDOFF;
                end
            end
            c_MEASURE: begin
                if (w_fall || w_wait_end) begin
                    w_state_nxt = c_HOLDOFF;
                end
            end
            c_HOLDOFF: begin
                if (w_hold_end) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Output decode: busy level and the two mutually exclusive publish events.
    always_comb begin
        w_busy     = (r_state != c_IDLE);
        w_pub_meas = 1'b0;
        w_pub_to   = 1'b0;
        case (r_state)
            c_WAIT_RISE: begin
                w_pub_to = w_wait_end && !w_rise;
            end
            c_MEASURE: begin
                w_pub_meas = w_fall;
                w_pub_to   = w_wait_end && !w_fall;
            end
            default: begin
                w_pub_meas = 1'b0;
                w_pub_to   = 1'b0;
            end
        endcase
    end

    // Distance in cm from the whole microseconds elapsed; result fits 10 bits.
    assign w_prod = {16'd0, r_us} * c_CM_MULT;
    assign w_dist = 10'(w_prod >> 16);

    // Registered pin/result outputs; trig follows the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_trig    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_echo_us <= 16'd0;
            r_dist_cm <= 10'd0;
        end else begin
            r_trig <= (w_state_nxt == c_TRIG);
            r_done <= w_pub_meas | w_pub_to;
            if (w_pub_meas) begin
                r_timeout <= 1'b0;
                r_echo_us <= r_us;
                r_dist_cm <= w_dist;
            end else if (w_pub_to) begin
                r_timeout <= 1'b1;
                r_echo_us <= 16'hFFFF;
                r_dist_cm <= 10'h3FF;
            end
        end
    end

    assign trig    = r_trig;
    assign busy    = w_busy;
    assign done    = r_done;
    assign timeout = r_timeout;
    assign echo_us = r_echo_us;
    assign dist_cm = r_dist_cm;

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_range_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ultrasonic_range_ctrl
// Description : Scoreboard bench for ultrasonic_range_ctrl. Two instances:
//               u_a (4 MHz, short timeout/holdoff) for sequencing corners,
//               u_b (2 MHz, 38000 us timeout) for nominal and long echoes.
//               Inputs are driven on the falling edge; outputs are sampled on
//               the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ultrasonic_range_ctrl;

    localparam int CYC    = 10;
    localparam int A_MHZ  = 4;
    localparam int A_TRIG = 10;
    localparam int A_TO   = 100;
    localparam int A_HOLD = 50;
    localparam int B_MHZ  = 2;
    localparam int B_TRIG = 10;
    localparam int B_TO   = 38000;
    localparam int B_HOLD = 50;

    typedef struct packed {
        logic        to;
        logic [15:0] us;
        logic [9:0]  cm;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_a_n, start_a, cont_a, echo_a;
    logic        trig_a, busy_a, done_a, timeout_a;
    logic [15:0] echo_us_a;
    logic [9:0]  dist_cm_a;
    logic        rst_b_n, start_b, cont_b, echo_b;
    logic        trig_b, busy_b, done_b, timeout_b;
    logic [15:0] echo_us_b;
    logic [9:0]  dist_cm_b;

    res_t qa[$];
    res_t qb[$];
    int   n_vec   = 0;
    int   n_bad   = 0;
    int   a_dones = 0;
    int   b_dones = 0;

    always #(CYC/2) clk = ~clk;

    ultrasonic_range_ctrl #(
        .CLKSPDMHZ(A_MHZ), .TRIG_US(A_TRIG), .TIMEOUT_US(A_TO), .HOLDOFF_US(A_HOLD)
    ) u_a (
        .clk(clk), .reset_n(rst_a_n), .start(start_a), .cont(cont_a), .echo(echo_a),
        .trig(trig_a), .busy(busy_a), .done(done_a), .timeout(timeout_a),
        .echo_us(echo_us_a), .dist_cm(dist_cm_a)
    );

    ultrasonic_range_ctrl #(
        .CLKSPDMHZ(B_MHZ), .TRIG_US(B_TRIG), .TIMEOUT_US(B_TO), .HOLDOFF_US(B_HOLD)
    ) u_b (
        .clk(clk), .reset_n(rst_b_n), .start(start_b), .cont(cont_b), .echo(echo_b),
        .trig(trig_b), .busy(busy_b), .done(done_b), .timeout(timeout_b),
        .echo_us(echo_us_b), .dist_cm(dist_cm_b)
    );

    function automatic res_t mk(input logic to, input logic [15:0] us, input logic [9:0] cm);
        res_t r;
        r.to = to;
        r.us = us;
        r.cm = cm;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // 0..2 = trig/busy/done of u_a, 3..5 = same of u_b
    function automatic logic sig(input int which);
        case (which)
            0:       return trig_a;
            1:       return busy_a;
            2:       return done_a;
            3:       return trig_b;
            4:       return busy_b;
            5:       return done_b;
            default: return 1'b0;
        endcase
    endfunction

    // Counts falling edges until the signal reads `level`; a blown budget is a failure.
    task automatic wait_sig(input int which, input logic level, input int budget,
                            input string name, output int cycles);
        cycles = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if (sig(which) == level) return;
            if (cycles >= budget) begin
                n_vec++;
                n_bad++;
                $display("FAIL %s: no event within %0d cycles", name, budget);
                return;
            end
        end
    endtask

    // Start pulse, then check the trigger width in clocks.
    task automatic go(input int d, input string name);
        int c;
        if (d == 0) start_a = 1'b1; else start_b = 1'b1;
        wait_sig(3*d, 1'b1, 10, {name, "_trig_rise"}, c);
        if (d == 0) start_a = 1'b0; else start_b = 1'b0;
        wait_sig(3*d, 1'b0, 1000, {name, "_trig_fall"}, c);
        chk({name, "_trig_width"}, c, (d == 0) ? A_TRIG*A_MHZ : B_TRIG*B_MHZ);
    endtask

    // Echo pulse of `width` clocks after `delay` clocks; done must follow the fall by 3.
    task automatic pulse(input int d, input int delay, input int width, input string name);
        int c;
        repeat (delay) @(negedge clk);
        if (d == 0) echo_a = 1'b1; else echo_b = 1'b1;
        repeat (width) @(negedge clk);
        if (d == 0) echo_a = 1'b0; else echo_b = 1'b0;
        wait_sig(3*d+2, 1'b1, 10, {name, "_done"}, c);
        chk({name, "_done_latency"}, c, 3);
    endtask

    task automatic seq_a();
        int c;
        int n0;
        // no echo: timeout 400 clk after trig falls, then 200 clk holdoff
        qa.push_back(mk(1'b1, 16'hFFFF, 10'h3FF));
        go(0, "a_noecho");
        wait_sig(2, 1'b1, 1000, "a_noecho_done", c);
        chk("a_noecho_done_latency", c, 400);
        wait_sig(1, 1'b0, 1000, "a_noecho_idle", c);
        chk("a_noecho_holdoff", c, 200);
        // 60 us echo (241 clk), extra start during MEASURE is ignored
        n0 = a_dones;
        qa.push_back(mk(1'b0, 16'd60, 10'd1));
        go(0, "a_busy");
        repeat (5) @(negedge clk);
        echo_a = 1'b1;
        repeat (100) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (140) @(negedge clk);
        echo_a = 1'b0;
        wait_sig(2, 1'b1, 10, "a_busy_done", c);
        chk("a_busy_done_latency", c, 3);
        wait_sig(1, 1'b0, 1000, "a_busy_idle", c);
        repeat (50) @(negedge clk);
        chk("a_busy_stays_idle", busy_a, 0);
        chk("a_busy_single_done", a_dones - n0, 1);
        // 1 us + 1 clk echo
        qa.push_back(mk(1'b0, 16'd1, 10'd0));
        go(0, "a_edge");
        pulse(0, 5, A_MHZ + 1, "a_edge");
        wait_sig(1, 1'b0, 1000, "a_edge_idle", c);
        // stuck-high echo, then stale echo on the next start
        qa.push_back(mk(1'b1, 16'hFFFF, 10'h3FF));
        qa.push_back(mk(1'b1, 16'hFFFF, 10'h3FF));
        go(0, "a_stuck");
        repeat (10) @(negedge clk);
        echo_a = 1'b1;
        wait_sig(2, 1'b1, 1000, "a_stuck_done", c);
        chk("a_stuck_done_latency", c, 403);
        wait_sig(1, 1'b0, 1000, "a_stuck_idle", c);
        go(0, "a_stale");
        wait_sig(2, 1'b1, 1000, "a_stale_done", c);
        chk("a_stale_done_latency", c, 400);
        wait_sig(1, 1'b0, 1000, "a_stale_idle", c);
        echo_a = 1'b0;
        repeat (5) @(negedge clk);
        // continuous mode: re-arm one clock after IDLE entry, stop after cont drops
        qa.push_back(mk(1'b1, 16'hFFFF, 10'h3FF));
        cont_a = 1'b1;
        wait_sig(2, 1'b1, 1000, "a_cont1_done", c);
        wait_sig(1, 1'b0, 1000, "a_cont1_idle", c);
        chk("a_cont_holdoff", c, 200);
        wait_sig(0, 1'b1, 10, "a_cont_rearm", c);
        chk("a_cont_rearm_latency", c, 1);
        qa.push_back(mk(1'b1, 16'hFFFF, 10'h3FF));
        cont_a = 1'b0;
        wait_sig(2, 1'b1, 1000, "a_cont2_done", c);
        wait_sig(1, 1'b0, 1000, "a_cont2_idle", c);
        repeat (20) @(negedge clk);
        chk("a_cont_stopped", busy_a, 0);
        // reset mid-TRIG: outputs clear before any clock edge
        start_a = 1'b1;
        wait_sig(0, 1'b1, 10, "a_rst_trig", c);
        start_a = 1'b0;
        repeat (20) @(negedge clk);
        #1 rst_a_n = 1'b0;
        #1;
        chk("a_rst_trig_async", trig_a, 0);
        chk("a_rst_busy", busy_a, 0);
        chk("a_rst_done", done_a, 0);
        chk("a_rst_timeout", timeout_a, 0);
        chk("a_rst_echo_us", echo_us_a, 0);
        chk("a_rst_dist_cm", dist_cm_a, 0);
        @(negedge clk);
        rst_a_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("a_post_rst_busy", busy_a, 0);
        chk("a_post_rst_trig", trig_a, 0);
    endtask

    task automatic seq_b();
        int c;
        // nominal: echo 200 us after trig falls, 580 us wide (+1 clk)
        qb.push_back(mk(1'b0, 16'd580, 10'd10));
        go(1, "b_nom");
        pulse(1, 400, 580*B_MHZ + 1, "b_nom");
        wait_sig(4, 1'b0, 1000, "b_nom_idle", c);
        chk("b_nom_holdoff", c, B_HOLD*B_MHZ);
        // longest valid echo, 37999 us (+1 clk)
        qb.push_back(mk(1'b0, 16'd37999, 10'd655));
        go(1, "b_long");
        pulse(1, 10, 37999*B_MHZ + 1, "b_long");
        wait_sig(4, 1'b0, 1000, "b_long_idle", c);
    endtask

    // Scoreboard monitor: every done pulse pops one expected result.
    initial begin : monitor
        res_t e;
        forever begin
            @(negedge clk);
            if (done_a === 1'b1) begin
                a_dones++;
                if (qa.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL a_unexpected_done: got done, expected none");
                end else begin
                    e = qa.pop_front();
                    chk("a_res_timeout", timeout_a, e.to);
                    chk("a_res_echo_us", echo_us_a, e.us);
                    chk("a_res_dist_cm", dist_cm_a, e.cm);
                end
            end
            if (done_b === 1'b1) begin
                b_dones++;
                if (qb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL b_unexpected_done: got done, expected none");
                end else begin
                    e = qb.pop_front();
                    chk("b_res_timeout", timeout_b, e.to);
                    chk("b_res_echo_us", echo_us_b, e.us);
                    chk("b_res_dist_cm", dist_cm_b, e.cm);
                end
            end
        end
    end

    initial begin : watchdog
        #(CYC*95000);
        $display("FAIL watchdog: run exceeded 95000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst_a_n = 1'b0; start_a = 1'b0; cont_a = 1'b0; echo_a = 1'b0;
        rst_b_n = 1'b0; start_b = 1'b0; cont_b = 1'b0; echo_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_a_trig", trig_a, 0);
        chk("reset_a_busy", busy_a, 0);
        chk("reset_a_done", done_a, 0);
        chk("reset_a_timeout", timeout_a, 0);
        chk("reset_a_echo_us", echo_us_a, 0);
        chk("reset_a_dist_cm", dist_cm_a, 0);
        chk("reset_b_trig", trig_b, 0);
        chk("reset_b_busy", busy_b, 0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        @(negedge clk);
        fork
            seq_a();
            seq_b();
        join
        repeat (10) @(negedge clk);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ultrasonic_range_ctrl.md
# ultrasonic_range_ctrl

Measurement sequencer for the HC-SR04-style ultrasonic ranging path. On a start request it issues the trigger pulse and waits for the echo to rise. It then times the echo width in microseconds and converts the width to centimetres. A holdoff follows before re-arming. It sits between the user/display logic and the sensor pins and replaces ad-hoc chaining of microsecond timers with one state machine plus a shared microsecond timebase.

## Interface
- CLKSPDMHZ, 100, clock frequency in MHz; clk cycles per microsecond tick
- TRIG_US, 10, trigger pulse width in µs
- TIMEOUT_US, 38000, maximum wait for echo rise, and maximum echo width, in µs (must be < 65535)
- HOLDOFF_US, 60000, idle gap after each measurement before the next can start, in µs
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request one measurement; sampled only in IDLE
- cont  in  1  continuous mode; when high, IDLE re-arms automatically
- echo  in  1  sensor echo pin, asynchronous to clk
- trig  out  1  sensor trigger pin, registered
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a result (or timeout) is published
- timeout  out  1  status of the last published result; 1 = no valid echo
- echo_us  out  16  last echo width in µs
- dist_cm  out  10  last distance in cm

## Operation
- echo passes through a 2-flop synchronizer, then a third flop for edge detection. Rise = sync & ~prev; fall = ~sync & prev.
- Timebase: prescaler runs 0..CLKSPDMHZ-1, and tick = (prescaler == CLKSPDMHZ-1). us_cnt[15:0] increments on tick. Both clear on every state entry.
- States and transitions:
  - IDLE: trig=0. Go to TRIG if start=1 or cont=1.
  - TRIG: trig=1. Go to WAIT_RISE on tick with us_cnt == TRIG_US-1.
  - WAIT_RISE: trig=0. Go to MEASURE on rise. Timeout: tick with us_cnt == TIMEOUT_US-1 goes to HOLDOFF.
  - MEASURE: go to HOLDOFF on fall, publishing echo_us = us_cnt. Timeout: tick with us_cnt == TIMEOUT_US-1 goes to HOLDOFF.
  - HOLDOFF: go to IDLE on tick with us_cnt == HOLDOFF_US-1.
- Publish on a successful measurement: echo_us = us_cnt (whole µs elapsed, truncated), dist_cm = (echo_us × 1130) >> 16 (≈ /58, 32-bit intermediate), timeout=0, done=1.
- Publish on a timeout in either waiting state: echo_us = 16'hFFFF, dist_cm = 10'h3FF, timeout=1, done=1.
- Publishing occurs exactly once per measurement. echo_us, dist_cm and timeout hold their values until the next publish.
- start is ignored while busy; no queuing.
- A fall in WAIT_RISE is ignored. A rise in MEASURE is ignored.
- If echo is already high on WAIT_RISE entry, no rise is detected until echo has returned low. A stale echo therefore times out.
- cont=1 sampled in IDLE re-arms; cont dropping mid-sequence completes the current measurement.

## Timing
- Reset values: state IDLE, trig=0, busy=0, done=0, timeout=0, echo_us=0, dist_cm=0, prescaler=0, us_cnt=0, sync flops 0. Reset asserted mid-sequence forces trig low immediately (asynchronous).
- start high at edge N (in IDLE) gives trig=1 and busy=1 from edge N+1.
- trig is high for exactly TRIG_US×CLKSPDMHZ cycles.
- echo rise to state MEASURE: 3 clk. Fall has the same latency, so the measured width is within ±1 clk of the true width, then truncated to µs.
- done asserts in the cycle after the fall is detected; the new outputs are valid in that same cycle.
- HOLDOFF entry to IDLE: HOLDOFF_US×CLKSPDMHZ cycles. busy deasserts with the IDLE entry.
- In cont mode the next trig rises 1 clk after IDLE entry.

## Test plan
- Nominal (CLKSPDMHZ=100): start pulse; echo rises 200 µs after trig falls and stays high 580 µs. Required: trig high 1000 clk, done pulse once, echo_us=580, dist_cm=10, timeout=0.
- No echo (TIMEOUT_US=100): start, echo held 0. Required: done 100 µs after trig falls, timeout=1, echo_us=16'hFFFF, dist_cm=10'h3FF, busy through holdoff.
- Stuck echo (TIMEOUT_US=100): echo rises and stays high. Required: done on the 100th µs tick in MEASURE with the timeout result. Then, with echo still high on the next start, WAIT_RISE times out again.
- Start while busy: second start pulse during MEASURE. Required: ignored, exactly one done. In cont=1 with HOLDOFF_US=50, back-to-back measurements: trig rises 1 clk after each IDLE entry.
- Reset mid-TRIG: reset_n low 500 clk into TRIG. Required: trig=0 asynchronously, all outputs at reset values, no done. After release with start=0, stays in IDLE.
- Edge widths: echo 1 µs + 1 clk gives echo_us=1, dist_cm=0. Echo 37999 µs (TIMEOUT_US=38000) gives echo_us=37999, dist_cm=655, timeout=0.
